// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from vga_timing_gen to its consumers.
// Optional frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if #(
  parameter int unsigned CNT_W = 10
);
  logic             p_tick;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             line_end;
  logic             frame_end;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  modport master (
    output p_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_end
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input p_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_end
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing generator with pixel-clock enable and registered syncs.
// Define VGA_FRAME_CNT_EN to add the 16-bit wrapping frame counter output.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned CNT_W     = 10
) (
  input  logic         CLK_100MHz,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP_C = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_DISP_C = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HS_START + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VS_START + V_SYNC - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_width
    $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("H_SYNC and V_SYNC must be at least 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hsync_q, vsync_q;
  logic             p_tick, hs_act_d, vs_act_d;
  logic             line_end, frame_end;

  always_comb begin
    p_tick = (div_q == DIV_LAST);
    div_d  = p_tick ? '0 : div_q + 1'b1;
    x_d    = x_q;
    y_d    = y_q;
    if (p_tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    // Decode the next counter values so the sync registers line up with the counters.
    hs_act_d  = (x_d >= HS_FIRST) && (x_d <= HS_LAST);
    vs_act_d  = (y_d >= VS_FIRST) && (y_d <= VS_LAST);
    line_end  = p_tick && (x_q == H_LAST);
    frame_end = line_end && (y_q == V_LAST);
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  assign vga.frame_cnt = frame_cnt_q;
`endif

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      if (p_tick) begin
        hsync_q <= hs_act_d ? HS_POL : ~HS_POL;
        vsync_q <= vs_act_d ? VS_POL : ~VS_POL;
      end
`ifdef VGA_FRAME_CNT_EN
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
    end
  end

  assign vga.p_tick    = p_tick;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.video_on  = (x_q < H_DISP_C) && (y_q < V_DISP_C);
  assign vga.pixel_x   = x_q;
  assign vga.pixel_y   = y_q;
  assign vga.line_end  = line_end;
  assign vga.frame_end = frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing plus a tiny CLK_DIV=1 timing in both
// sync polarities, checked cycle by cycle against closed-form expected values.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.CNT_W(10)) if_def ();
  vga_timing_if #(.CNT_W(4))  if_sml ();
  vga_timing_if #(.CNT_W(4))  if_pol ();

  vga_timing_gen u_def (
    .CLK_100MHz (clk),
    .reset      (reset),
    .vga        (if_def)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CNT_W(4)
  ) u_sml (
    .CLK_100MHz (clk),
    .reset      (reset),
    .vga        (if_sml)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) u_pol (
    .CLK_100MHz (clk),
    .reset      (reset),
    .vga        (if_pol)
  );

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // k = rising edges since reset release.
  task automatic check_all(input int k);
    int  t, x, y;
    bit  pt, le;
    pt = (k % 4) == 3;
    t  = k / 4;
    x  = t % 800;
    y  = (t / 800) % 525;
    le = pt && (x == 799);
    check("def.p_tick",    k, 32'(if_def.p_tick),    32'(pt));
    check("def.pixel_x",   k, 32'(if_def.pixel_x),   32'(x));
    check("def.pixel_y",   k, 32'(if_def.pixel_y),   32'(y));
    check("def.hsync",     k, 32'(if_def.hsync),     32'(!(x >= 656 && x <= 751)));
    check("def.vsync",     k, 32'(if_def.vsync),     32'(!(y >= 490 && y <= 491)));
    check("def.video_on",  k, 32'(if_def.video_on),  32'(x < 640 && y < 480));
    check("def.line_end",  k, 32'(if_def.line_end),  32'(le));
    check("def.frame_end", k, 32'(if_def.frame_end), 32'(le && y == 524));

    x  = k % 14;
    y  = (k / 14) % 7;
    le = (x == 13);
    check("sml.p_tick",    k, 32'(if_sml.p_tick),    32'(1));
    check("sml.pixel_x",   k, 32'(if_sml.pixel_x),   32'(x));
    check("sml.pixel_y",   k, 32'(if_sml.pixel_y),   32'(y));
    check("sml.hsync",     k, 32'(if_sml.hsync),     32'(!(x >= 10 && x <= 11)));
    check("sml.vsync",     k, 32'(if_sml.vsync),     32'(y != 5));
    check("sml.video_on",  k, 32'(if_sml.video_on),  32'(x < 8 && y < 4));
    check("sml.line_end",  k, 32'(if_sml.line_end),  32'(le));
    check("sml.frame_end", k, 32'(if_sml.frame_end), 32'(le && y == 6));
    check("pol.hsync",     k, 32'(if_pol.hsync),     32'(x >= 10 && x <= 11));
    check("pol.vsync",     k, 32'(if_pol.vsync),     32'(y == 5));
    check("pol.pixel_x",   k, 32'(if_pol.pixel_x),   32'(x));
`ifdef VGA_FRAME_CNT_EN
    check("sml.frame_cnt", k, 32'(if_sml.frame_cnt), 32'((k / 98) % 65536));
`endif
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Held in reset.
    check("rst.def.hsync",     0, 32'(if_def.hsync),     32'(1));
    check("rst.def.vsync",     0, 32'(if_def.vsync),     32'(1));
    check("rst.def.pixel_x",   0, 32'(if_def.pixel_x),   32'(0));
    check("rst.def.pixel_y",   0, 32'(if_def.pixel_y),   32'(0));
    check("rst.def.video_on",  0, 32'(if_def.video_on),  32'(1));
    check("rst.def.p_tick",    0, 32'(if_def.p_tick),    32'(0));
    check("rst.def.line_end",  0, 32'(if_def.line_end),  32'(0));
    check("rst.def.frame_end", 0, 32'(if_def.frame_end), 32'(0));
    check("rst.sml.p_tick",    0, 32'(if_sml.p_tick),    32'(1));
    check("rst.pol.hsync",     0, 32'(if_pol.hsync),     32'(0));
    check("rst.pol.vsync",     0, 32'(if_pol.vsync),     32'(0));

    reset = 1'b0;
    #1;
    check_all(0);

    // Covers a full default line, the default hsync window and many small frames.
    for (int k = 1; k <= 4400; k++) begin
      @(negedge clk);
      check_all(k);
    end
    check("mid.def.pixel_x", 4400, 32'(if_def.pixel_x), 32'(300));
    check("mid.def.pixel_y", 4400, 32'(if_def.pixel_y), 32'(1));

    // Asynchronous reset mid-frame takes effect without a clock edge.
    reset = 1'b1;
    #1;
    check("arst.def.pixel_x",  0, 32'(if_def.pixel_x),  32'(0));
    check("arst.def.pixel_y",  0, 32'(if_def.pixel_y),  32'(0));
    check("arst.def.hsync",    0, 32'(if_def.hsync),    32'(1));
    check("arst.def.video_on", 0, 32'(if_def.video_on), 32'(1));
    check("arst.def.p_tick",   0, 32'(if_def.p_tick),   32'(0));
    check("arst.sml.pixel_x",  0, 32'(if_sml.pixel_x),  32'(0));
    check("arst.pol.hsync",    0, 32'(if_pol.hsync),    32'(0));
`ifdef VGA_FRAME_CNT_EN
    check("arst.sml.frame_cnt", 0, 32'(if_sml.frame_cnt), 32'(0));
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("rel.def.pixel_x", k, 32'(if_def.pixel_x), 32'(0));
      check("rel.def.p_tick",  k, 32'(if_def.p_tick),  32'(k == 3));
    end
    @(negedge clk);
    check("rel.def.pixel_x", 4, 32'(if_def.pixel_x), 32'(1));
    check("rel.sml.pixel_x", 4, 32'(if_sml.pixel_x), 32'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
